// File: rtl/fp_mul_wb.sv
// Write-back buffer for FP multiplier results: 2-entry FIFO, sticky fflags, retire counter.
// Optional trap-on-flag support enabled by defining FP_WB_TRAP_EN.
module fp_mul_wb #(
    parameter int E = 8,
    parameter int F = 23
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [E+F:0]   in_y,
    input  logic [4:0]     in_flags,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [E+F:0]   out_y,
    output logic [4:0]     out_flags,
    output logic [4:0]     fflags,
    input  logic           fflags_clr,
    output logic [15:0]    retired,
    input  logic [4:0]     trap_mask,
    output logic           trap
);
    localparam int W = E + F + 1;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] head_y_q, head_y_d, tail_y_q, tail_y_d;
    logic [4:0]   head_f_q, head_f_d, tail_f_q, tail_f_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [4:0]   fflags_q, fflags_d;
    logic [15:0]  retired_q, retired_d;
    logic         trap_d;
    logic         push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        state_d  = state_q;
        head_y_d = head_y_q;
        head_f_d = head_f_q;
        tail_y_d = tail_y_q;
        tail_f_d = tail_f_q;
        case (state_q)
            EMPTY: if (push) begin
                state_d  = ONE;
                head_y_d = in_y;
                head_f_d = in_flags;
            end
            ONE: begin
                if (push && pop) begin
                    head_y_d = in_y;
                    head_f_d = in_flags;
                end else if (push) begin
                    state_d  = FULL;
                    tail_y_d = in_y;
                    tail_f_d = in_flags;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (pop) begin
                state_d  = ONE;
                head_y_d = tail_y_q;
                head_f_d = tail_f_q;
            end
            default: state_d = EMPTY;
        endcase
    end

    // A clear coinciding with a pop still keeps the popped entry's flags.
    assign fflags_d  = (fflags_clr ? 5'd0 : fflags_q) | (pop ? head_f_q : 5'd0);
    assign retired_d = (pop && retired_q != 16'hFFFF) ? retired_q + 16'd1 : retired_q;

`ifdef FP_WB_TRAP_EN
    logic trap_q;
    // Set wins over clear when both land on the same edge.
    assign trap_d = (pop && |(head_f_q & trap_mask)) ? 1'b1 :
                    (fflags_clr ? 1'b0 : trap_q);

    always_ff @(posedge clk) begin
        if (!rst_n) trap_q <= 1'b0;
        else        trap_q <= trap_d;
    end

    assign trap = trap_q;
`else
    logic unused_trap_mask;
    assign unused_trap_mask = ^trap_mask;
    assign trap_d = 1'b0;
    assign trap   = 1'b0;
`endif

    assign in_ready_d  = (state_d != FULL);
    assign out_valid_d = (state_d != EMPTY) && !trap_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_y_q    <= '0;
            head_f_q    <= '0;
            tail_y_q    <= '0;
            tail_f_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            fflags_q    <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_y_q    <= head_y_d;
            head_f_q    <= head_f_d;
            tail_y_q    <= tail_y_d;
            tail_f_q    <= tail_f_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            fflags_q    <= fflags_d;
            retired_q   <= retired_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = head_y_q;
    assign out_flags = head_f_q;
    assign fflags    = fflags_q;
    assign retired   = retired_q;
endmodule

// File: doc/fp_mul_wb.md
FP_MUL_WB -- requirements
Module: fp_mul_wb

Interface
REQ-001 SHALL have parameter E, default 8, exponent width of the carried IEEE-754 result.
REQ-002 SHALL have parameter F, default 23, fraction width of the carried IEEE-754 result.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  multiplier result {in_y,in_flags} is presented.
REQ-006 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-007 SHALL have port in_y  input  E+F+1  multiplier result {sign,exp,frac}.
REQ-008 SHALL have port in_flags  input  5  multiplier flags {NV,DZ,OF,UF,NX}.
REQ-009 SHALL have port out_valid  output  1  head entry is available to the consumer.
REQ-010 SHALL have port out_ready  input  1  consumer takes the head entry.
REQ-011 SHALL have port out_y  output  E+F+1  head entry result.
REQ-012 SHALL have port out_flags  output  5  head entry flags.
REQ-013 SHALL have port fflags  output  5  sticky accumulated exception flags, same bit order as in_flags.
REQ-014 SHALL have port fflags_clr  input  1  one-cycle request to clear fflags and trap.
REQ-015 SHALL have port retired  output  16  saturating count of popped entries.
REQ-016 SHALL have port trap_mask  input  5  per-flag trap enable, same bit order.
REQ-017 SHALL have port trap  output  1  sticky trap indication.

Function
REQ-018 SHALL buffer results in a 2-entry FIFO; the states are EMPTY, ONE and FULL.
REQ-019 SHALL define push as in_valid&&in_ready and pop as out_valid&&out_ready.
REQ-020 SHALL drive in_ready = (state!=FULL) directly from a register, with no combinational path from out_ready.
REQ-021 SHALL drive out_valid = (state!=EMPTY), and SHALL drive out_y and out_flags from the head register with no input-to-output combinational path.
REQ-022 SHALL use the following state transitions, with all unlisted combinations holding state:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL.
  - ONE: pop only -> EMPTY.
  - ONE: push and pop -> ONE, with the new entry becoming head.
  - FULL: pop -> ONE, with the second entry becoming head.
REQ-023 SHALL present an entry pushed at edge N into an EMPTY FIFO on out_* from cycle N+1 (latency 1).
REQ-024 SHALL preserve FIFO order, and SHALL neither drop nor duplicate entries.
REQ-025 SHALL ignore in_y and in_flags when no push occurs, and SHALL keep out_y and out_flags stable while out_valid=1 and out_ready=0.
REQ-026 SHALL update fflags on each edge as next = (fflags_clr ? 0 : fflags) | (pop ? out_flags : 0), so a clear in the same cycle as a pop keeps the popped flags.
REQ-027 SHALL accumulate flags only on pop, never on push.
REQ-028 SHALL increment retired by 1 per pop, and SHALL saturate it at 16'hFFFF without wrapping.

Reset
REQ-029 SHALL, on the first clk edge with rst_n=0, set:
  - state = EMPTY, so in_ready=1 and out_valid=0;
  - out_y = 0, out_flags = 0, fflags = 0;
  - retired = 0, trap = 0.
REQ-030 SHALL discard buffered entries on a reset asserted mid-operation; no pop and no fflags update SHALL occur on that edge.

Configuration
REQ-031 SHALL, when macro FP_WB_TRAP_EN is defined:
  - set trap at the edge of any pop with (out_flags & trap_mask)!=0;
  - clear trap only by fflags_clr or reset, with set winning when both occur on the same edge;
  - force out_valid=0 (retirement halted, pushes still accepted until FULL) while trap=1.
REQ-032 SHALL, when FP_WB_TRAP_EN is undefined, tie trap to 0, ignore trap_mask, and contain no trap logic.

Verification
REQ-033 SHALL cover: reset, then push 32'h3F800000 flags 5'b00000 with out_ready=1 -> out_valid=1 next cycle, out_y=32'h3F800000, retired=1 after pop.
REQ-034 SHALL cover: out_ready=0, pushes 32'h40000000, 32'h40400000, 32'h40800000 -> in_ready=0 after the second push, the third is held off; then out_ready=1 -> outputs 40000000, 40400000, 40800000 in order.
REQ-035 SHALL cover: state ONE, simultaneous push of 32'h7F800000 (flags 5'b00100) and pop -> state stays ONE, head=7F800000, fflags gains only the popped entry's flags.
REQ-036 SHALL cover: pop of an entry with flags 5'b00001 in the same cycle as fflags_clr=1 -> fflags=5'b00001 next cycle.
REQ-037 SHALL cover: with FP_WB_TRAP_EN, trap_mask=5'b10000, pop of 32'h7FC00000 with flags 5'b10000 -> trap=1 and out_valid=0 next cycle; fflags_clr -> trap=0 and retirement resumes; without the macro, trap stays 0.
REQ-038 SHALL cover: retired preset near saturation by 65535 pops, then one more pop -> retired=16'hFFFF.
